// File: rtl/wb_host_master.sv
// rtl/wb_host_master.sv - Wishbone classic single-transfer initiator with command/response handshakes
// One command in flight at a time; each command becomes exactly one read or write bus cycle.

module wb_host_master #(
  parameter int TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_we,
  input  logic [31:0] cmd_adr,
  input  logic [31:0] cmd_dat,
  input  logic [3:0]  cmd_sel,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_dat,
  output logic        rsp_err,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUS  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);

  logic [1:0]  state;
  logic [15:0] timer;
  logic        cyc_q;

  // cyc and stb are one register: transfers are never pipelined.
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = cyc_q;
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= ST_IDLE;
      timer     <= 16'd0;
      cmd_ready <= 1'b0;
      cyc_q     <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'd0;
      wbm_adr_o <= 32'd0;
      wbm_dat_o <= 32'd0;
      rsp_valid <= 1'b0;
      rsp_dat   <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            cyc_q     <= 1'b1;
            wbm_we_o  <= cmd_we;
            wbm_sel_o <= cmd_sel;
            wbm_adr_o <= cmd_adr;
            wbm_dat_o <= cmd_we ? cmd_dat : 32'd0;
            timer     <= 16'd0;
            state     <= ST_BUS;
          end else begin
            cmd_ready <= 1'b1;
          end
        end

        ST_BUS: begin
          // An ack on the timeout edge takes priority over the abort.
          if (wbm_ack_i) begin
            cyc_q     <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'd0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
            rsp_dat   <= wbm_we_o ? 32'd0 : wbm_dat_i;
            rsp_err   <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else if (timer == TIMER_LAST) begin
            cyc_q     <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'd0;
            wbm_adr_o <= 32'd0;
            wbm_dat_o <= 32'd0;
            rsp_dat   <= 32'd0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_dat   <= 32'd0;
            rsp_err   <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= ST_IDLE;
          end
        end

        default: begin
          state     <= ST_IDLE;
          cmd_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/wb_host_master.md
# wb_host_master

Wishbone classic single-transfer initiator that drives the user-project Wishbone slave port from on-chip logic (bring-up sequencer, LA-driven test host). It accepts one command at a time on a valid/ready command channel and runs exactly one Wishbone read or write. It waits for `ack` with a bounded timeout and returns read data plus an error flag on a valid/ready response channel.

## Interface

Parameters:
- `TIMEOUT`, default 255: bus cycles with `stb` high and no `ack` before abort. Legal range is 1..65535; the internal counter is 16 bits.

Ports:
- `wb_clk_i`  in  1  the single clock.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `cmd_valid`  in  1  command present.
- `cmd_ready`  out  1  block can accept a command.
- `cmd_we`  in  1  1 = write, 0 = read.
- `cmd_adr`  in  32  byte address.
- `cmd_dat`  in  32  write data.
- `cmd_sel`  in  4  byte lane selects.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_dat`  out  32  read data; 0 for writes and for aborts.
- `rsp_err`  out  1  1 = timeout abort.
- `wbm_cyc_o`, `wbm_stb_o`  out  1 each  bus cycle / strobe.
- `wbm_we_o`  out  1  write enable.
- `wbm_sel_o`  out  4  byte selects.
- `wbm_adr_o`  out  32  address.
- `wbm_dat_o`  out  32  write data.
- `wbm_dat_i`  in  32  read data from the slave.
- `wbm_ack_i`  in  1  slave acknowledge.
- `busy`  out  1  state is not IDLE.

## Operation

- FSM states: IDLE, BUS, RESP. All Wishbone and response outputs are registered.
- IDLE:
  - `cmd_ready` = 1; all other outputs are 0.
  - When `cmd_valid` & `cmd_ready` at an edge: latch `we`, `adr`, `sel`, and `dat` (`dat` is forced to 0 for reads), set `cyc` = `stb` = 1, clear the timer, go to BUS.
- BUS:
  - `cyc`, `stb`, `we`, `adr`, `sel`, and `dat` are held constant. `cmd_ready` = 0.
  - `wbm_ack_i` = 1 at an edge: drop `cyc`/`stb`/`we`, capture `rsp_dat` = `wbm_dat_i` for a read or 0 for a write, set `rsp_err` = 0 and `rsp_valid` = 1, go to RESP.
  - Otherwise, if timer == `TIMEOUT`-1: drop `cyc`/`stb`, set `rsp_dat` = 0, `rsp_err` = 1, `rsp_valid` = 1, go to RESP.
  - Otherwise the timer increments by 1.
- RESP:
  - `rsp_valid` = 1 and `rsp_dat`/`rsp_err` are held stable until `rsp_ready` = 1 at an edge.
  - On that edge, clear `rsp_valid`, `rsp_dat`, and `rsp_err`, and go to IDLE.
- `wbm_ack_i` is ignored outside BUS. A late ack after an abort has no effect.
- `wbm_adr_o`, `wbm_sel_o`, and `wbm_dat_o` return to 0 when `cyc` drops.
- Transfers are never pipelined and there are no bursts. `cyc` and `stb` are always identical.

## Timing

- Reset values (asynchronous, applied immediately, including mid-transaction): every output is 0, state is IDLE, timer is 0. `cmd_ready` is forced to 0 while `wb_rst_i` = 1 and is 1 from the first edge after release.
- If a command is accepted at edge k, `cyc`/`stb` are high from after edge k.
- The first `ack` sample is at edge k+1. If ack is sampled at edge m, `cyc`/`stb` are low and `rsp_valid` is high after edge m.
- If the response is taken at edge r, `cmd_ready` = 1 after edge r.
- Minimum cost is 3 edges per transaction: accept, ack, response.
- Timeout: with no ack, `stb` stays high for exactly `TIMEOUT` cycles and the abort happens at edge k+`TIMEOUT`.
- If `ack` arrives on the same edge as the timeout, ack wins and `rsp_err` = 0.
- `rsp_ready` held high in IDLE or BUS has no effect.

## Test plan

- **Write, immediate ack.** Command `we`=1, `adr`=0x3000_0004, `dat`=0xCAFE_F00D, `sel`=0xF; slave acks on the first cycle.
  - `cyc`/`stb` are high for exactly 1 cycle with those values.
  - `rsp_valid` rises the next cycle with `rsp_dat`=0 and `rsp_err`=0.
- **Read, 3-cycle wait.** Command `we`=0, `adr`=0x3000_0000; slave acks on the 4th cycle with 0x1234_5678.
  - `stb` is high for 4 cycles and `wbm_dat_o`=0 throughout.
  - `rsp_dat`=0x1234_5678 and `rsp_err`=0.
- **Timeout.** `TIMEOUT`=8, no ack.
  - `stb` is high for exactly 8 cycles.
  - `rsp_err`=1 and `rsp_dat`=0.
  - An ack injected 2 cycles later is ignored, and state stays RESP.
- **Ack on the timeout edge.** `TIMEOUT`=8, ack on the 8th cycle with 0xA5A5_A5A5 → `rsp_err`=0 and `rsp_dat`=0xA5A5_A5A5.
- **Backpressure.**
  - Hold `rsp_ready`=0 for 5 cycles: `rsp_valid`/`rsp_dat` are stable and `cmd_ready`=0, with `cmd_valid` held high throughout.
  - Release `rsp_ready`: the next command is accepted 1 cycle after the response is taken.
- **Reset mid-transfer.** Assert `wb_rst_i` while in BUS.
  - `cyc`/`stb`/`rsp_valid` go to 0 with no clock edge.
  - After release, a new read completes normally.
